// File: rtl/axil_apb_pkg.sv
// Shared AXI response encodings and bridge FSM states for the AXI4-Lite to multi-slave APB bridge.
package axil_apb_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_ACCESS,
      ST_RESP
   } bridge_state_t;

   // Width of the slave-select address field; a single slave still needs one bit.
   function automatic int sel_width(input int num_slaves);
      return (num_slaves > 1) ? $clog2(num_slaves) : 1;
   endfunction

endpackage

// File: rtl/apb_slave_decoder.sv
// Turns the slave-select address field into a one-hot PSEL vector plus a miss flag,
// and steers the selected slave's PRDATA/PREADY/PSLVERR back to the bridge.
module apb_slave_decoder
   import axil_apb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int NUM_SLAVES = 4,
   parameter int SEL_W      = sel_width(NUM_SLAVES)
) (
   input  logic [SEL_W-1:0]             sel_field,
   input  logic [NUM_SLAVES*DATA_W-1:0] prdata,
   input  logic [NUM_SLAVES-1:0]        pready,
   input  logic [NUM_SLAVES-1:0]        pslverr,
   output logic [NUM_SLAVES-1:0]        sel_onehot,
   output logic                         miss,
   output logic [DATA_W-1:0]            sel_prdata,
   output logic                         sel_pready,
   output logic                         sel_pslverr
);

   // Only indices below NUM_SLAVES can match, so out-of-range fields leave everything at zero.
   always_comb begin
      miss        = (int'(sel_field) >= NUM_SLAVES);
      sel_onehot  = '0;
      sel_prdata  = '0;
      sel_pready  = 1'b0;
      sel_pslverr = 1'b0;
      for (int i = 0; i < NUM_SLAVES; i++) begin
         if (int'(sel_field) == i) begin
            sel_onehot[i] = 1'b1;
            sel_prdata    = prdata[i*DATA_W +: DATA_W];
            sel_pready    = pready[i];
            sel_pslverr   = pslverr[i];
         end
      end
   end

endmodule

// File: rtl/axil_apb_bridge_mux.sv
// AXI4-Lite slave to multi-slave APB master bridge: one outstanding transaction,
// alternating read/write priority, PREADY wait states with an optional timeout.
module axil_apb_bridge_mux
   import axil_apb_pkg::*;
#(
   parameter int  ADDR_W         = 32,
   parameter int  DATA_W         = 32,
   parameter int  NUM_SLAVES     = 4,
   parameter int  SLV_SEL_LSB    = 12,
   parameter int  TIMEOUT_CYCLES = 256,
   localparam int STRB_W         = DATA_W / 8
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [ADDR_W-1:0]            awaddr,
   input  logic                         awvalid,
   output logic                         awready,
   input  logic [DATA_W-1:0]            wdata,
   input  logic [STRB_W-1:0]            wstrb,
   input  logic                         wvalid,
   output logic                         wready,
   output logic [1:0]                   bresp,
   output logic                         bvalid,
   input  logic                         bready,
   input  logic [ADDR_W-1:0]            araddr,
   input  logic                         arvalid,
   output logic                         arready,
   output logic [DATA_W-1:0]            rdata,
   output logic [1:0]                   rresp,
   output logic                         rvalid,
   input  logic                         rready,
   output logic [ADDR_W-1:0]            PADDR,
   output logic [NUM_SLAVES-1:0]        PSEL,
   output logic                         PENABLE,
   output logic                         PWRITE,
   output logic [DATA_W-1:0]            PWDATA,
   output logic [STRB_W-1:0]            PSTRB,
   input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
   input  logic [NUM_SLAVES-1:0]        PREADY,
   input  logic [NUM_SLAVES-1:0]        PSLVERR
);

   localparam int SEL_W = sel_width(NUM_SLAVES);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] TO_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   bridge_state_t     state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0] strb_q, strb_d;
   logic              write_q, write_d;
   logic [1:0]        resp_q, resp_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic              wr_prio_q, wr_prio_d;
   logic [CNT_W-1:0]  tcnt_q, tcnt_d;

   logic              grant_wr, grant_rd;
   logic [ADDR_W-1:0] dec_addr;
   logic [NUM_SLAVES-1:0] dec_onehot;
   logic              dec_miss, dec_pready, dec_pslverr;
   logic [DATA_W-1:0] dec_prdata;

   // In IDLE the decoder looks at the winning candidate so a miss is known at accept time.
   always_comb begin
      grant_wr = awvalid && wvalid && (wr_prio_q || !arvalid);
      grant_rd = arvalid && !grant_wr;
      dec_addr = addr_q;
      if (state_q == ST_IDLE) begin
         dec_addr = grant_wr ? awaddr : araddr;
      end
   end

   apb_slave_decoder #(
      .DATA_W     (DATA_W),
      .NUM_SLAVES (NUM_SLAVES),
      .SEL_W      (SEL_W)
   ) u_decoder (
      .sel_field   (dec_addr[SLV_SEL_LSB +: SEL_W]),
      .prdata      (PRDATA),
      .pready      (PREADY),
      .pslverr     (PSLVERR),
      .sel_onehot  (dec_onehot),
      .miss        (dec_miss),
      .sel_prdata  (dec_prdata),
      .sel_pready  (dec_pready),
      .sel_pslverr (dec_pslverr)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      strb_d    = strb_q;
      write_d   = write_q;
      resp_d    = resp_q;
      rdata_d   = rdata_q;
      wr_prio_d = wr_prio_q;
      tcnt_d    = tcnt_q;
      awready   = 1'b0;
      wready    = 1'b0;
      arready   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (grant_wr || grant_rd) begin
               awready   = rst_n && grant_wr;
               wready    = rst_n && grant_wr;
               arready   = rst_n && grant_rd;
               addr_d    = grant_wr ? awaddr : araddr;
               write_d   = grant_wr;
               wdata_d   = grant_wr ? wdata : wdata_q;
               strb_d    = grant_wr ? wstrb : '0;
               wr_prio_d = !grant_wr;
               tcnt_d    = '0;
               if (dec_miss) begin
                  resp_d  = RESP_DECERR;
                  rdata_d = '0;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_SETUP;
               end
            end
         end
         ST_SETUP: state_d = ST_ACCESS;
         ST_ACCESS: begin
            if (dec_pready) begin
               resp_d  = dec_pslverr ? RESP_SLVERR : RESP_OKAY;
               if (dec_pslverr) begin
                  rdata_d = '0;
               end else if (!write_q) begin
                  rdata_d = dec_prdata;
               end
               state_d = ST_RESP;
            end else if ((TIMEOUT_CYCLES != 0) && (tcnt_q == TO_LAST)) begin
               resp_d  = RESP_SLVERR;
               rdata_d = '0;
               state_d = ST_RESP;
            end else begin
               tcnt_d = tcnt_q + 1'b1;
            end
         end
         ST_RESP: begin
            if ((write_q && bready) || (!write_q && rready)) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      PSEL    = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) ? dec_onehot : '0;
      PENABLE = (state_q == ST_ACCESS);
      PADDR   = addr_q;
      PWRITE  = write_q;
      PWDATA  = wdata_q;
      PSTRB   = strb_q;
      bvalid  = (state_q == ST_RESP) && write_q;
      rvalid  = (state_q == ST_RESP) && !write_q;
      bresp   = resp_q;
      rresp   = resp_q;
      rdata   = rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= '0;
         wdata_q   <= '0;
         strb_q    <= '0;
         write_q   <= 1'b0;
         resp_q    <= RESP_OKAY;
         rdata_q   <= '0;
         wr_prio_q <= 1'b1;
         tcnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         strb_q    <= strb_d;
         write_q   <= write_d;
         resp_q    <= resp_d;
         rdata_q   <= rdata_d;
         wr_prio_q <= wr_prio_d;
         tcnt_q    <= tcnt_d;
      end
   end

endmodule

// File: doc/axil_apb_bridge_mux.md
Name: axil_apb_bridge_mux

Overview:
Parametrised AXI4-Lite slave to multi-slave APB master bridge, successor to the write-only AXI-to-APB bridge. Handles both reads and writes and decodes one APB select per slave from an address field. Supports PREADY wait states, maps PSLVERR, decode misses and wait-state timeouts onto AXI BRESP/RRESP. Sits between the AXI master and a bank of APB peripherals in the top-level system.

Parameters:
ADDR_W, 32, AXI/APB address width
DATA_W, 32, data width (8/16/32/64); STRB_W = DATA_W/8
NUM_SLAVES, 4, APB slaves (1..16); SEL_W = max(1, clog2(NUM_SLAVES))
SLV_SEL_LSB, 12, LSB of the address field selecting the slave
TIMEOUT_CYCLES, 256, max ACCESS cycles awaiting PREADY; 0 disables the timeout

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
awaddr  in  ADDR_W  write address
awvalid/awready  in/out  1  AW handshake
wdata  in  DATA_W  write data
wstrb  in  STRB_W  write strobes
wvalid/wready  in/out  1  W handshake
bresp  out  2  write response
bvalid/bready  out/in  1  B handshake
araddr  in  ADDR_W  read address
arvalid/arready  in/out  1  AR handshake
rdata  out  DATA_W  read data
rresp  out  2  read response
rvalid/rready  out/in  1  R handshake
PADDR  out  ADDR_W  APB address
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  access phase
PWRITE  out  1  1 = write
PWDATA  out  DATA_W  write data
PSTRB  out  STRB_W  write strobes
PRDATA  in  NUM_SLAVES*DATA_W  read data, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset (async assert, sync release): all outputs 0, FSM in IDLE, write-priority flag set. An in-flight transaction is dropped silently; no response is issued.
- FSM states: IDLE, SETUP, ACCESS, RESP. One transaction is outstanding at a time.
- IDLE accept conditions:
  - Write candidate: awvalid && wvalid together. awready and wready are asserted combinationally in the same cycle, so AW and W are accepted jointly; a lone AW or a lone W is never accepted.
  - Read candidate: arvalid; arready is asserted combinationally.
- Arbitration: if both candidates are present, the one holding priority wins. After each accepted transaction, priority flips to the other type (alternating).
- On accept: latch addr, wdata, wstrb and direction. Compute idx = addr[SLV_SEL_LSB +: SEL_W].
  - idx < NUM_SLAVES: go to SETUP.
  - idx >= NUM_SLAVES: decode miss; go directly to RESP with resp=DECERR (2'b11) and rdata=0. No APB activity.
- SETUP (1 cycle): PSEL[idx]=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid. PSTRB=0 on reads. Go to ACCESS.
- ACCESS: PENABLE=1; all APB outputs held stable.
  - On PREADY[idx]=1: capture PRDATA slice and PSLVERR[idx]. resp = SLVERR (2'b10) if PSLVERR else OKAY (2'b00). Deassert PSEL/PENABLE, go to RESP.
  - PRDATA is captured only on reads; rdata is forced to 0 on any error.
- Timeout: a counter clears on entry to SETUP and increments each ACCESS cycle without PREADY. When the count reaches TIMEOUT_CYCLES (nonzero), abort: PSEL/PENABLE go to 0, resp = SLVERR, rdata = 0, go to RESP.
- RESP: drive bvalid (write) or rvalid (read) with the registered resp/rdata, held stable until bready/rready. The handshake cycle returns to IDLE.
- Throughput: a new accept is possible in the cycle after the B/R handshake. awready, wready and arready are 0 outside IDLE.
- Latency: accept at T0, SETUP T1, ACCESS T2. With zero wait states, bvalid/rvalid is asserted at T3. Each wait state adds 1 cycle. A decode miss responds at T1.
- Invariants: PSEL is one-hot or zero. PENABLE implies PSEL != 0. bvalid and rvalid are never both 1.

Decomposition:
- Package axil_apb_pkg: AXI resp encodings (OKAY, SLVERR, DECERR) and the FSM state enum.
- One sub-module, apb_slave_decoder: combinational idx, one-hot PSEL vector, decode-miss flag, and the PRDATA/PREADY/PSLVERR mux.
- Bridge top contains the FSM, arbitration flag, timeout counter and AXI holding registers.

Test Plan:
1. Write addr 0x0000_1010, data 0xDEAD_BEEF, wstrb 0xF; slave 1 PREADY at once -> PSEL=4'b0010 for 2 cycles, PWDATA=0xDEAD_BEEF, bvalid at T3 with bresp=00.
2. Read addr 0x0000_3004; slave 3 returns 0x1234_5678 after 3 wait states -> rvalid at T6, rdata=0x1234_5678, rresp=00, PSTRB=0.
3. Simultaneous AW+W and AR valid from reset -> write granted first, then the read; repeating both streams alternates W, R, W, R.
4. NUM_SLAVES=3, read addr 0x0000_3000 -> no PSEL asserted, rvalid at T1, rresp=11, rdata=0. Slave 2 with PSLVERR=1 -> bresp=10.
5. TIMEOUT_CYCLES=8, slave never asserts PREADY -> PENABLE high exactly 8 cycles, then dropped; bresp=10. Next transaction completes normally.
6. Assert rst_n=0 during ACCESS with bready=0 -> PSEL, PENABLE, bvalid and all readies go to 0 immediately; after release, a fresh write completes with OKAY.
